light_phase_sequencer: RTL and testbench

//  Producer side of the countdown/colour display path. Steps a traffic light through GREEN -> YELLOW -> RED.

---
 rtl/light_phase_sequencer_pkg.sv | 41 ++++
 rtl/light_phase_sequencer_if.sv | 24 ++
 rtl/light_phase_sequencer_phase_counter.sv | 35 +++
 rtl/light_phase_sequencer.sv | 92 +++++++++
 tb/tb_light_phase_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/light_phase_sequencer_pkg.sv
// Shared colour codes, phase encodings and helpers for the traffic-light sequencer.
package light_phase_sequencer_pkg;

  localparam logic [2:0] COL_RED    = 3'b011;
  localparam logic [2:0] COL_YELLOW = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b101;

  localparam int MAX_SECONDS = 25;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  // Out-of-range phase durations fall back to the longest legal phase.
  function automatic logic [4:0] clamp_time(input int t);
    if (t < 1 || t > MAX_SECONDS) begin
      return 5'(MAX_SECONDS);
    end
    return 5'(t);
  endfunction

  function automatic logic [2:0] phase_colour(input phase_e p);
    case (p)
      PH_GREEN:  return COL_GREEN;
      PH_YELLOW: return COL_YELLOW;
      default:   return COL_RED;
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/light_phase_sequencer_if.sv
// Control inputs and display outputs of the sequencer, grouped as one bundle.
interface light_phase_sequencer_if;

  logic       Tick;
  logic       Start;
  logic       Pause;
  logic       Skip;
  logic [2:0] Colour;
  logic [4:0] Count;
  logic       CountValid;
  logic       PhaseDone;
  logic       Running;

  modport master (
    output Tick, Start, Pause, Skip,
    input  Colour, Count, CountValid, PhaseDone, Running
  );

  modport slave (
    input  Tick, Start, Pause, Skip,
    output Colour, Count, CountValid, PhaseDone, Running
  );

endinterface

// File: rtl/light_phase_sequencer_phase_counter.sv
// Loadable 5-bit seconds down-counter; Load beats Dec and the count never wraps below 1.
module light_phase_sequencer_phase_counter (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Load,
  input  logic [4:0] LoadValue,
  input  logic       Dec,
  output logic [4:0] Count,
  output logic       AtOne
);

  logic [4:0] count_q;
  logic [4:0] count_d;

  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = LoadValue;
    end else if (Dec && count_q > 5'd1) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      count_q <= 5'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
  assign AtOne = (count_q == 5'd1);

endmodule

// File: rtl/light_phase_sequencer.sv
// Steps a traffic light GREEN -> YELLOW -> RED on one-second ticks, with pause and skip control.
module light_phase_sequencer
  import light_phase_sequencer_pkg::*;
#(
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int RED_TIME    = 20
) (
  input  logic                        ClockIn,
  input  logic                        Reset,
  light_phase_sequencer_if.slave      bus
);

  localparam logic [4:0] GREEN_LOAD  = clamp_time(GREEN_TIME);
  localparam logic [4:0] YELLOW_LOAD = clamp_time(YELLOW_TIME);
  localparam logic [4:0] RED_LOAD    = clamp_time(RED_TIME);

  phase_e     state_q, state_d;
  logic [2:0] colour_q, colour_d;
  logic       done_q, done_d;
  logic       running_q, running_d;

  logic       cnt_load;
  logic       cnt_dec;
  logic [4:0] cnt_load_value;
  logic [4:0] cnt_value;
  logic       cnt_at_one;

  light_phase_sequencer_phase_counter u_counter (
    .ClockIn   (ClockIn),
    .Reset     (Reset),
    .Load      (cnt_load),
    .LoadValue (cnt_load_value),
    .Dec       (cnt_dec),
    .Count     (cnt_value),
    .AtOne     (cnt_at_one)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (state_q == PH_IDLE) begin
      if (bus.Start) begin
        state_d  = PH_GREEN;
        cnt_load = 1'b1;
      end
    end else if (!bus.Pause) begin
      // Skip and an expiring Tick share one advance, so both together still give one PhaseDone.
      if (bus.Skip || (bus.Tick && cnt_at_one)) begin
        state_d  = next_phase(state_q);
        cnt_load = 1'b1;
        done_d   = 1'b1;
      end else if (bus.Tick) begin
        cnt_dec = 1'b1;
      end
    end

    case (state_d)
      PH_GREEN:  cnt_load_value = GREEN_LOAD;
      PH_YELLOW: cnt_load_value = YELLOW_LOAD;
      PH_RED:    cnt_load_value = RED_LOAD;
      default:   cnt_load_value = 5'd0;
    endcase

    colour_d  = phase_colour(state_d);
    running_d = (state_d != PH_IDLE);
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q   <= PH_IDLE;
      colour_q  <= COL_RED;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      colour_q  <= colour_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign bus.Colour     = colour_q;
  assign bus.Count      = cnt_value;
  assign bus.CountValid = running_q;
  assign bus.PhaseDone  = done_q;
  assign bus.Running    = running_q;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Directed and randomized checks of light_phase_sequencer against a behavioural light model.
module tb_light_phase_sequencer;

  localparam int G_T = 3;
  localparam int Y_T = 2;
  localparam int R_T = 4;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  light_phase_sequencer_if bus ();

  light_phase_sequencer #(
    .GREEN_TIME  (G_T),
    .YELLOW_TIME (Y_T),
    .RED_TIME    (R_T)
  ) dut (
    .ClockIn (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = green, 2 = yellow, 3 = red
  int m_phase = 0;
  int m_count = 0;
  int m_done  = 0;
  int done_seen = 0;
  int phase_secs [4] = '{0, G_T, Y_T, R_T};
  logic [2:0] phase_col [4] = '{3'b011, 3'b101, 3'b001, 3'b011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 0;
    m_done  = 0;
  endtask

  task automatic model_edge(input bit tick, input bit start, input bit pause, input bit skip);
    m_done = 0;
    if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_count = phase_secs[1];
      end
    end else if (!pause) begin
      if (skip || (tick && m_count == 1)) begin
        m_phase = (m_phase == 3) ? 1 : m_phase + 1;
        m_count = phase_secs[m_phase];
        m_done  = 1;
      end else if (tick) begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".colour"},  32'(bus.Colour),     32'(phase_col[m_phase]));
    chk({ctx, ".count"},   32'(bus.Count),      32'(m_count));
    chk({ctx, ".valid"},   32'(bus.CountValid), 32'(m_phase != 0));
    chk({ctx, ".done"},    32'(bus.PhaseDone),  32'(m_done));
    chk({ctx, ".running"}, 32'(bus.Running),    32'(m_phase != 0));
  endtask

  // Called at a falling edge: drive inputs, clock once, compare at the next falling edge.
  task automatic step(input string ctx, input bit tick, input bit start, input bit pause, input bit skip);
    bus.Tick  = tick;
    bus.Start = start;
    bus.Pause = pause;
    bus.Skip  = skip;
    @(posedge clk);
    model_edge(tick, start, pause, skip);
    @(negedge clk);
    if (bus.PhaseDone === 1'b1) done_seen++;
    $display("step %-8s tick=%0b start=%0b pause=%0b skip=%0b -> colour=%b count=%0d done=%0b",
             ctx, tick, start, pause, skip, bus.Colour, bus.Count, bus.PhaseDone);
    compare_all(ctx);
  endtask

  // Reset asserted mid-cycle; outputs must change before any clock edge.
  task automatic apply_reset(input string ctx);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all({ctx, ".async"});
    @(negedge clk);
    rst = 1'b0;
    compare_all({ctx, ".held"});
    $display("reset %s applied", ctx);
  endtask

  initial begin
    bus.Tick = 0; bus.Start = 0; bus.Pause = 0; bus.Skip = 0;

    // 1: reset with no clock running
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("t1");
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare_all("t1.rel");

    // 2: start then three ticks into yellow with a single PhaseDone
    step("t2.start", 0, 1, 0, 0);
    chk("t2.cnt3", 32'(bus.Count), 32'd3);
    step("t2.tick", 1, 0, 0, 0);
    step("t2.tick", 1, 0, 0, 0);
    step("t2.tick", 1, 0, 0, 0);
    chk("t2.yellow", 32'(bus.Colour), 32'h1);
    chk("t2.y2", 32'(bus.Count), 32'd2);
    chk("t2.pd", 32'(bus.PhaseDone), 32'd1);
    step("t2.idle", 0, 0, 0, 0);
    chk("t2.pd_low", 32'(bus.PhaseDone), 32'd0);

    // 3: full cycle back to green, counting PhaseDone pulses
    apply_reset("t3");
    step("t3.start", 0, 1, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) step("t3.tick", 1, 0, 0, 0);
    chk("t3.red", 32'(bus.Colour), 32'h3);
    chk("t3.r4", 32'(bus.Count), 32'd4);
    for (int i = 0; i < 4; i++) step("t3.tick", 1, 0, 0, 0);
    chk("t3.green", 32'(bus.Colour), 32'h5);
    chk("t3.g3", 32'(bus.Count), 32'd3);
    chk("t3.pulses", 32'(done_seen), 32'd3);

    // 4: pause freezes everything, dropped tick and skip
    for (int i = 0; i < 5; i++) step("t4.pause", 1, 0, 1, 0);
    step("t4.pskip", 0, 0, 1, 1);
    chk("t4.cnt", 32'(bus.Count), 32'd3);
    chk("t4.col", 32'(bus.Colour), 32'h5);
    step("t4.rel", 0, 0, 0, 0);
    chk("t4.pd", 32'(bus.PhaseDone), 32'd0);

    // 5: skip and tick together give one advance
    step("t5.both", 1, 0, 0, 1);
    chk("t5.y", 32'(bus.Colour), 32'h1);
    chk("t5.y2", 32'(bus.Count), 32'd2);
    chk("t5.pd", 32'(bus.PhaseDone), 32'd1);
    step("t5.after", 0, 0, 0, 0);
    chk("t5.pd_low", 32'(bus.PhaseDone), 32'd0);

    // 6: reset in red with count 2, then restart
    step("t6.skip", 0, 0, 0, 1);
    step("t6.tick", 1, 0, 0, 0);
    step("t6.tick", 1, 0, 0, 0);
    chk("t6.red2", 32'(bus.Count), 32'd2);
    apply_reset("t6");
    chk("t6.rcol", 32'(bus.Colour), 32'h3);
    step("t6.start", 0, 1, 0, 0);
    chk("t6.g3", 32'(bus.Count), 32'd3);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset("rnd");
      end else begin
        step("rnd",
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 14) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
